seq_wsum: RTL and testbench
===========================

# seq_wsum

Parametrised sequential weighted-sum unit: computes O = Σ COEF[k]·I[k] over N_CH unsigned channels using one shared multiply-accumulate datapath, one channel per clock. It is the generalised successor of the fixed three-channel 23/18/13 weighted-sum block. It adds:
- run-time-writable coefficients,
- a start/busy/done handshake,
- selectable wrap or saturate output arithmetic.

## Interface
- N_CH, 3, number of input channels (≥1)
- DW, 8, channel data width
- CW, 5, coefficient width (unsigned)
- OW, 16, output width
- SAT, 0, 0 = output wraps modulo 2^OW; 1 = output saturates to 2^OW−1
- COEF_INIT, {5'd13,5'd18,5'd23}, packed reset coefficients; channel 0 in LSBs
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request operation; sampled in IDLE only
- din  input  N_CH*DW  packed channel data, channel 0 in LSBs; captured on accepted start
- coef_we  input  1  coefficient write strobe
- coef_addr  input  clog2(N_CH) (min 1)  coefficient index
- coef_wdata  input  CW  coefficient value
- busy  output  1  high from cycle after accepted start through DONE cycle
- done  output  1  one-cycle pulse when O is updated
- O  output  OW  result, held until next done

## Operation
- States:
  - IDLE
    - start=1 → snapshot din into input register; clear accumulator; idx=0; go to ACC.
  - ACC
    - each cycle: acc += coef[idx]·din_reg[idx]; idx++.
    - After idx = N_CH−1 → DONE.
  - DONE
    - O ← final acc, wrapped or saturated per SAT; done=1; go to IDLE.
- Accumulator width AW = DW+CW+clog2(N_CH); never overflows internally.
- Wrap: O = acc[OW−1:0]. Saturate: O = (acc ≥ 2^OW) ? 2^OW−1 : acc. If OW ≥ AW, O is acc zero-extended and SAT has no effect.
- din changes after the accepted start have no effect on the running operation.
- Coefficient writes:
  - In IDLE, coef_we updates coef[coef_addr] at the edge.
  - In ACC/DONE, coef_we is ignored (write dropped, no error).
  - coef_addr ≥ N_CH is ignored.
  - A write and a start in the same IDLE cycle: the write lands, and the operation uses the new coefficient.
- start while busy: ignored, not queued. start in the DONE cycle: ignored.
- Reset values: O=0, busy=0, done=0, state=IDLE, acc=0, idx=0, coefficients=COEF_INIT.
- reset mid-operation: operation abandoned, no done pulse, coefficients revert to COEF_INIT.

## Timing
- Start accepted at edge E0.
- ACC occupies edges E1..E_N_CH.
- DONE is entered after edge E_N_CH.
- O and done are registered at edge E_(N_CH+1). Latency from accepted start to O valid = N_CH+1 cycles (4 for defaults).
- Minimum start-to-start spacing = N_CH+2 cycles; the next start is accepted in the first IDLE cycle after DONE.
- busy is registered and rises the cycle after start is accepted. done and busy are both high in the DONE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, ACC, DONE);
  - clog2 function;
  - default coefficient constants 23/18/13.
- Sub-module seq_wsum_coef_rf: N_CH×CW register file, async reset to COEF_INIT, one write port gated by the top-level write-enable (coef_we qualified by state==IDLE), one combinational read port indexed by idx.
- Top level holds the FSM, input snapshot register, index counter, MAC datapath and output wrap/saturate logic.

## Test plan
- Defaults, din = 255/255/255 at start → done exactly 4 cycles later, O = 13770.
- Back-to-back operations:
  - din = 10/20/30 → O = 980;
  - then din = 72/134/201 → O = 6681;
  - O holds 980 until the second done.
- Write coef[1] = 31 in IDLE, then din = 10/20/30 → O = 1240. A write to coef[0] issued while busy is dropped: next run still uses 23.
- OW=12, din = 255/255/255:
  - SAT=0 → O = 1482;
  - SAT=1 → O = 4095.
- start held high continuously with din changing every cycle:
  - exactly one done per 5 cycles;
  - each result matches the din present at the accepted start.
- reset asserted mid-ACC (with coef[2] previously rewritten):
  - O, busy, done drop to 0 immediately;
  - no done pulse;
  - the following run with 10/20/30 gives 980 (coefficients back to COEF_INIT).

Source files
------------

// File: rtl/seq_wsum_pkg.sv
// Shared definitions for the sequential weighted-sum unit: FSM encoding,
// reset coefficient values and a constant-evaluable clog2.
package seq_wsum_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [4:0] DEF_COEF0 = 5'd23;
   localparam logic [4:0] DEF_COEF1 = 5'd18;
   localparam logic [4:0] DEF_COEF2 = 5'd13;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_wsum_coef_rf.sv
// Coefficient register file: one gated write port, one combinational read port,
// asynchronously reset to the packed initial coefficient vector.
module seq_wsum_coef_rf
   import seq_wsum_pkg::*;
#(
   parameter int N_CH = 3,
   parameter int CW = 5,
   parameter int IW = 2,
   parameter logic [N_CH*CW-1:0] COEF_INIT = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [CW-1:0] wdata,
   input  logic [IW-1:0] raddr,
   output logic [CW-1:0] rdata
);

   logic [N_CH*CW-1:0] coef_flat;

   // Addresses at or above N_CH match no entry, so such writes simply vanish.
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_entry
         logic [CW-1:0] coef_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               coef_reg <= COEF_INIT[gi*CW +: CW];
            end else if (we && (waddr == IW'(gi))) begin
               coef_reg <= wdata;
            end
         end

         assign coef_flat[gi*CW +: CW] = coef_reg;
      end
   endgenerate

   always_comb begin
      rdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (raddr == IW'(i)) begin
            rdata = coef_flat[i*CW +: CW];
         end
      end
   end

endmodule

// File: rtl/seq_wsum.sv
// Sequential weighted sum O = sum(coef[k]*din[k]) using one shared MAC,
// one channel per clock, with start/busy/done handshake and wrap/saturate output.
module seq_wsum
   import seq_wsum_pkg::*;
#(
   parameter int N_CH = 3,
   parameter int DW = 8,
   parameter int CW = 5,
   parameter int OW = 16,
   parameter int SAT = 0,
   parameter logic [N_CH*CW-1:0] COEF_INIT = {DEF_COEF2, DEF_COEF1, DEF_COEF0},
   localparam int IW = (clog2(N_CH) < 1) ? 1 : clog2(N_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_CH*DW-1:0] din,
   input  logic               coef_we,
   input  logic [IW-1:0]      coef_addr,
   input  logic [CW-1:0]      coef_wdata,
   output logic               busy,
   output logic               done,
   output logic [OW-1:0]      O
);

   localparam int AW = DW + CW + clog2(N_CH);

   state_t             state_reg, state_next;
   logic [N_CH*DW-1:0] din_reg, din_next;
   logic [IW-1:0]      idx_reg, idx_next;
   logic [AW-1:0]      acc_reg, acc_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic [OW-1:0]      o_reg, o_next;

   logic [CW-1:0]      coef_rd;
   logic [DW-1:0]      ch_sel;
   logic [AW-1:0]      prod;
   logic [OW-1:0]      o_fmt;
   logic               coef_wr_en;

   // Writes only land while idle so a running sum never sees a coefficient change.
   assign coef_wr_en = coef_we && (state_reg == ST_IDLE);

   seq_wsum_coef_rf #(
      .N_CH      (N_CH),
      .CW        (CW),
      .IW        (IW),
      .COEF_INIT (COEF_INIT)
   ) u_coef_rf (
      .clk   (clk),
      .reset (reset),
      .we    (coef_wr_en),
      .waddr (coef_addr),
      .wdata (coef_wdata),
      .raddr (idx_reg),
      .rdata (coef_rd)
   );

   always_comb begin
      ch_sel = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (idx_reg == IW'(i)) begin
            ch_sel = din_reg[i*DW +: DW];
         end
      end
   end

   assign prod = AW'(coef_rd) * AW'(ch_sel);

   // Saturation only matters when the accumulator can exceed the output range.
   generate
      if ((SAT != 0) && (OW < AW)) begin : g_sat
         assign o_fmt = (|acc_reg[AW-1:OW]) ? '1 : acc_reg[OW-1:0];
      end else begin : g_wrap
         assign o_fmt = OW'(acc_reg);
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      din_next   = din_reg;
      idx_next   = idx_reg;
      acc_next   = acc_reg;
      o_next     = o_reg;
      done_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               din_next   = din;
               acc_next   = '0;
               idx_next   = '0;
               state_next = ST_ACC;
            end
         end
         ST_ACC: begin
            acc_next = acc_reg + prod;
            if (idx_reg == IW'(N_CH - 1)) begin
               idx_next   = '0;
               state_next = ST_DONE;
            end else begin
               idx_next = idx_reg + IW'(1);
            end
         end
         ST_DONE: begin
            o_next     = o_fmt;
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      busy_next = (state_next != ST_IDLE) || done_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         din_reg   <= '0;
         idx_reg   <= '0;
         acc_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         o_reg     <= '0;
      end else begin
         state_reg <= state_next;
         din_reg   <= din_next;
         idx_reg   <= idx_next;
         acc_reg   <= acc_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         o_reg     <= o_next;
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign O    = o_reg;

endmodule

// File: tb/tb_seq_wsum.sv
// Self-checking bench for seq_wsum: default unit plus 12-bit wrap and saturate
// variants, scoreboarded results popped on every done pulse.
module tb_seq_wsum;

   logic        clk;
   logic        reset;
   logic        start;
   logic [23:0] din;
   logic        coef_we;
   logic [1:0]  coef_addr;
   logic [4:0]  coef_wdata;

   logic        busy16, done16;
   logic [15:0] o16;
   logic        busy12w, done12w;
   logic [11:0] o12w;
   logic        busy12s, done12s;
   logic [11:0] o12s;

   int checks = 0;
   int errors = 0;
   int mc [3];
   int held16 = 0;
   int q16[$];
   int q12w[$];
   int q12s[$];

   seq_wsum dut16 (
      .clk(clk), .reset(reset), .start(start), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .busy(busy16), .done(done16), .O(o16)
   );

   seq_wsum #(.OW(12), .SAT(0)) dut12w (
      .clk(clk), .reset(reset), .start(start), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .busy(busy12w), .done(done12w), .O(o12w)
   );

   seq_wsum #(.OW(12), .SAT(1)) dut12s (
      .clk(clk), .reset(reset), .start(start), .din(din),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .busy(busy12s), .done(done12s), .O(o12s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wsum(input int d0, input int d1, input int d2);
      return mc[0] * d0 + mc[1] * d1 + mc[2] * d2;
   endfunction

   task automatic push_exp(input int d0, input int d1, input int d2, output int e16);
      int s;
      s = wsum(d0, d1, d2);
      e16 = s % 65536;
      q16.push_back(e16);
      q12w.push_back(s % 4096);
      q12s.push_back((s > 4095) ? 4095 : s);
      $display("push din=%0d/%0d/%0d coef=%0d/%0d/%0d sum=%0d", d0, d1, d2, mc[0], mc[1], mc[2], s);
   endtask

   // Scoreboard side: every done pulse must consume one expected result.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (done16 === 1'b1) begin
            chk("sb16_nonempty", 32'(q16.size() > 0), 1);
            if (q16.size() > 0) begin
               int e;
               e = q16.pop_front();
               $display("done O16=%0d expected %0d", o16, e);
               chk("O16", o16, e);
            end
         end
         if (done12w === 1'b1) begin
            chk("sb12w_nonempty", 32'(q12w.size() > 0), 1);
            if (q12w.size() > 0) chk("O12w", o12w, q12w.pop_front());
         end
         if (done12s === 1'b1) begin
            chk("sb12s_nonempty", 32'(q12s.size() > 0), 1);
            if (q12s.size() > 0) chk("O12s", o12s, q12s.pop_front());
         end
      end
   end

   task automatic coef_write(input int addr, input int val);
      @(negedge clk);
      coef_we    = 1'b1;
      coef_addr  = 2'(addr);
      coef_wdata = 5'(val);
      @(negedge clk);
      coef_we = 1'b0;
      $display("coef write addr=%0d val=%0d", addr, val);
   endtask

   // One operation; optional coefficient write in the start cycle (sw_*) or while busy (bw_*).
   task automatic run(input int d0, input int d1, input int d2,
                      input int sw_addr, input int sw_val,
                      input int bw_addr, input int bw_val,
                      output int lat);
      int e16;
      @(negedge clk);
      din   = {8'(d2), 8'(d1), 8'(d0)};
      start = 1'b1;
      if (sw_addr >= 0) begin
         coef_we    = 1'b1;
         coef_addr  = 2'(sw_addr);
         coef_wdata = 5'(sw_val);
         if (sw_addr < 3) mc[sw_addr] = sw_val;
      end
      push_exp(d0, d1, d2, e16);
      @(posedge clk);
      #1;
      start   = 1'b0;
      coef_we = 1'b0;
      chk("busy_rise", busy16, 1);
      chk("O_hold_start", o16, held16);
      if (bw_addr >= 0) begin
         coef_we    = 1'b1;
         coef_addr  = 2'(bw_addr);
         coef_wdata = 5'(bw_val);
      end
      lat = 0;
      while ((done16 !== 1'b1) && (lat < 30)) begin
         @(posedge clk);
         #1;
         coef_we = 1'b0;
         lat++;
         if (lat == 3) chk("O_hold_mid", o16, held16);
      end
      chk("done_seen", done16, 1);
      chk("busy_in_done", busy16, 1);
      held16 = e16;
      @(posedge clk);
      #1;
      chk("done_pulse_end", done16, 0);
      chk("busy_end", busy16, 0);
   endtask

   initial begin
      int lat;
      int nd;
      int d [3];
      mc[0] = 23; mc[1] = 18; mc[2] = 13;
      reset = 1'b0; start = 1'b0; din = '0;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

      #2 reset = 1'b1;
      #1;
      chk("rst_O16", o16, 0);
      chk("rst_busy", busy16, 0);
      chk("rst_done", done16, 0);
      chk("rst_O12s", o12s, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Full-scale inputs: latency and 12-bit wrap/saturate behaviour
      run(255, 255, 255, -1, 0, -1, 0, lat);
      chk("latency", lat, 4);

      // Back-to-back runs
      run(10, 20, 30, -1, 0, -1, 0, lat);
      run(72, 134, 201, -1, 0, -1, 0, lat);

      // Coefficient rewrite in idle, out-of-range write, write while busy dropped
      coef_write(1, 31);
      mc[1] = 31;
      coef_write(3, 0);
      run(10, 20, 30, -1, 0, 0, 5, lat);
      run(10, 20, 30, -1, 0, -1, 0, lat);

      // Write and start in the same idle cycle
      run(10, 20, 30, 2, 20, -1, 0, lat);

      // start held high with din changing each cycle
      begin
         int e;
         @(negedge clk);
         for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
               @(negedge clk);
               chk("held_done_timing", done16, 32'(c % 5 == 0));
            end
            d[0] = $urandom_range(255); d[1] = $urandom_range(255); d[2] = $urandom_range(255);
            din   = {8'(d[2]), 8'(d[1]), 8'(d[0])};
            start = 1'b1;
            if (c % 5 == 0) push_exp(d[0], d[1], d[2], e);
         end
         @(negedge clk);
         chk("held_done_last", done16, 1);
         start = 1'b0;
         held16 = e;
         @(posedge clk);
         #1;
         chk("held_idle_busy", busy16, 0);
      end

      // Reset mid-ACC after coef[2] was rewritten
      @(negedge clk);
      din   = {8'd30, 8'd20, 8'd10};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_O16", o16, 0);
      chk("midrst_busy", busy16, 0);
      chk("midrst_done", done16, 0);
      chk("midrst_O12w", o12w, 0);
      q16.delete(); q12w.delete(); q12s.delete();
      mc[0] = 23; mc[1] = 18; mc[2] = 13;
      held16 = 0;
      @(negedge clk);
      reset = 1'b0;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (done16 === 1'b1) nd++;
      end
      chk("no_done_after_rst", nd, 0);
      run(10, 20, 30, -1, 0, -1, 0, lat);

      repeat (3) @(negedge clk);
      chk("sb16_drained", q16.size(), 0);
      chk("sb12s_drained", q12s.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
